alu_op_sequencer: RTL and testbench

Upstream issue stage for the `SimpleAlu` datapath.
- Accepts operand/opcode triples on a valid/ready stream, buffers them and issues one per cycle to the ALU operand registers.
- Captures `X`/`Z` after a fixed ALU latency and presents results, in order, on a backpressured output stream.
- Credit-based issue guarantees results never overflow when the consumer stalls.

---
 rtl/alu_op_sequencer_if.sv | 34 +++
 rtl/alu_op_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Bundles the three streams around the ALU issue stage:
//     - input stream   : in_valid/in_ready with operand/opcode triple in_a/in_b/in_op
//     - ALU operands   : alu_a/alu_b/alu_op out, alu_x/alu_z back from the ALU
//     - result stream  : out_valid/out_ready with out_x/out_z/out_err
//   modport slave  : the sequencer itself
//   modport master : the environment (producer, ALU, consumer)
interface alu_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_x;
  logic        alu_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x;
  logic        out_z;
  logic        out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_x, alu_z, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_x, out_z, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_x, alu_z, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_x, out_z, out_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue stage in front of the SimpleAlu datapath. Triples are buffered in an
//   input FIFO, issued one per cycle into the registered ALU operand ports, and
//   the ALU result is captured ALU_LATENCY edges later into a result FIFO that
//   feeds a backpressured output stream. Issue is credit limited so captured
//   results always have a free result-FIFO slot.
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : alu_op_sequencer_if.slave (input stream, ALU operands/results,
//             result stream)
// Parameters:
//   DEPTH       : entries per FIFO, power of two, >= 2
//   ALU_LATENCY : edges from alu_* update to valid alu_x/alu_z, 1..4
// Optional feature macro: ALU_SEQ_OP_CHECK_EN
//   When defined, opcode 7 takes an issue slot without loading the ALU and
//   produces a result of x=0, z=0, err=1. When undefined out_err is tied 0.
module alu_op_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  alu_op_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_CX = (CW+1)'(DEPTH);

  // Input FIFO: {op, b, a}
  logic [66:0]          in_mem [DEPTH];
  logic [AW-1:0]        in_wr;
  logic [AW-1:0]        in_rd;
  logic [CW-1:0]        in_count;

  // Result FIFO: {x, z}
  logic [32:0]          res_mem [DEPTH];
  logic [AW-1:0]        res_wr;
  logic [AW-1:0]        res_rd;
  logic [CW-1:0]        res_count;

  logic [ALU_LATENCY-1:0] vld_sr;
  logic                   ready_en;

  logic        push;
  logic        issue;
  logic        capture;
  logic        pop;
  logic        load_alu;
  logic        credit_ok;
  logic [CW-1:0] inflight;
  logic [31:0] head_a;
  logic [31:0] head_b;
  logic [2:0]  head_op;
  logic [31:0] cap_x;
  logic        cap_z;

  assign {head_op, head_b, head_a} = in_mem[in_rd];

  // ready_en keeps in_ready low while in reset and lets it rise on the first
  // edge after release, still without any combinational input dependence.
  assign bus.in_ready = ready_en && (in_count != DEPTH_C);
  assign push         = bus.in_valid && bus.in_ready;
  assign credit_ok    = ({1'b0, inflight} + {1'b0, res_count}) < DEPTH_CX;
  assign issue        = (in_count != '0) && credit_ok;
  assign capture      = vld_sr[ALU_LATENCY-1];
  assign bus.out_valid = (res_count != '0);
  assign pop          = bus.out_valid && bus.out_ready;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ALU_LATENCY; i++) begin
      inflight = inflight + CW'(vld_sr[i]);
    end
  end

`ifdef ALU_SEQ_OP_CHECK_EN
  logic [ALU_LATENCY-1:0] err_sr;
  logic                   res_err [DEPTH];
  logic                   head_err;

  assign head_err = (head_op == 3'd7);
  assign load_alu = issue && !head_err;
  assign cap_x    = err_sr[ALU_LATENCY-1] ? '0 : bus.alu_x;
  assign cap_z    = err_sr[ALU_LATENCY-1] ? 1'b0 : bus.alu_z;
  assign bus.out_err = bus.out_valid && res_err[res_rd];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_sr <= '0;
    end else begin
      for (int unsigned i = 1; i < ALU_LATENCY; i++) begin
        err_sr[i] <= err_sr[i-1];
      end
      err_sr[0] <= issue && head_err;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      res_err[res_wr] <= err_sr[ALU_LATENCY-1];
    end
  end
`else
  assign load_alu    = issue;
  assign cap_x       = bus.alu_x;
  assign cap_z       = bus.alu_z;
  assign bus.out_err = 1'b0;
`endif

  // Head is gated by out_valid so outputs read zero when the FIFO is empty
  // (including in reset) without resetting the storage array.
  assign bus.out_x = bus.out_valid ? res_mem[res_rd][32:1] : '0;
  assign bus.out_z = bus.out_valid && res_mem[res_rd][0];

  always_ff @(posedge clk) begin
    if (push) begin
      in_mem[in_wr] <= {bus.in_op, bus.in_b, bus.in_a};
    end
    if (capture) begin
      res_mem[res_wr] <= {cap_x, cap_z};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en   <= 1'b0;
      in_wr      <= '0;
      in_rd      <= '0;
      in_count   <= '0;
      res_wr     <= '0;
      res_rd     <= '0;
      res_count  <= '0;
      vld_sr     <= '0;
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= '0;
    end else begin
      ready_en <= 1'b1;

      if (push)    in_wr  <= in_wr + AW'(1);
      if (issue)   in_rd  <= in_rd + AW'(1);
      if (capture) res_wr <= res_wr + AW'(1);
      if (pop)     res_rd <= res_rd + AW'(1);

      case ({push, issue})
        2'b10:   in_count <= in_count + CW'(1);
        2'b01:   in_count <= in_count - CW'(1);
        default: in_count <= in_count;
      endcase

      case ({capture, pop})
        2'b10:   res_count <= res_count + CW'(1);
        2'b01:   res_count <= res_count - CW'(1);
        default: res_count <= res_count;
      endcase

      for (int unsigned i = 1; i < ALU_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      vld_sr[0] <= issue;

      if (load_alu) begin
        bus.alu_a  <= head_a;
        bus.alu_b  <= head_b;
        bus.alu_op <= head_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Self-checking bench for alu_op_sequencer at DEPTH=4, ALU_LATENCY=1.
//   A combinational SimpleAlu model closes the ALU loop. Expected results are
//   computed per accepted triple and kept in an in-order queue.
module tb_alu_op_sequencer;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] x;
    logic        z;
  } vec_t;

  logic clk;
  logic resetn;
  alu_op_sequencer_if bus();

  alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LATENCY(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = ~(a | b);
      3'd3: alu_f = a | b;
      3'd4: alu_f = ~(a & b);
      3'd5: alu_f = a & b;
      3'd6: alu_f = ~(a ^ b);
      default: alu_f = a ^ b;
    endcase
  endfunction

  assign bus.alu_x = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_z = (alu_f(bus.alu_a, bus.alu_b, bus.alu_op) == 32'd0);

  // Expected {err, z, x} for one accepted triple.
  function automatic logic [33:0] exp_of(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [31:0] x;
`ifdef ALU_SEQ_OP_CHECK_EN
    if (op == 3'd7) return {1'b1, 1'b0, 32'd0};
`endif
    x = alu_f(a, b, op);
    return {1'b0, (x == 32'd0), x};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int accepts  = 0;
  int outs     = 0;
  logic sb_en  = 1'b0;
  logic [33:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs already set; returns after the
  // next negedge so outputs are sampled mid-cycle.
  task automatic cycle();
    logic acc_in, acc_out, hold;
    logic [33:0] held, tmp;
    acc_in  = bus.in_valid && bus.in_ready;
    acc_out = bus.out_valid && bus.out_ready;
    hold    = bus.out_valid && !bus.out_ready;
    held    = {bus.out_err, bus.out_z, bus.out_x};
    if (acc_out) outs++;
    if (sb_en) begin
      if (acc_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: got result %0h, expected none", held);
        end else begin
          tmp = exp_q.pop_front();
          chk("sb_result", 64'(held), 64'(tmp));
        end
      end
      if (acc_in) exp_q.push_back(exp_of(bus.in_a, bus.in_b, bus.in_op));
    end
    if (acc_in) accepts++;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      chk("stall_valid", 64'(bus.out_valid), 64'(1));
      chk("stall_data", 64'({bus.out_err, bus.out_z, bus.out_x}), 64'(held));
    end
`ifdef ALU_SEQ_OP_CHECK_EN
    chk("alu_op_not7", 64'(bus.alu_op == 3'd7), 64'(0));
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'(0));
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_alu_a"},     64'(bus.alu_a),     64'(0));
    chk({tag, "_alu_b"},     64'(bus.alu_b),     64'(0));
    chk({tag, "_alu_op"},    64'(bus.alu_op),    64'(0));
    chk({tag, "_out_x"},     64'(bus.out_x),     64'(0));
    chk({tag, "_out_z"},     64'(bus.out_z),     64'(0));
    chk({tag, "_out_err"},   64'(bus.out_err),   64'(0));
  endtask

  task automatic drain(input int budget);
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_out_valid", 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [9];
    vecs[0] = '{32'd5,        32'd3,        3'd0, 32'd8,          1'b0};
    vecs[1] = '{32'd7,        32'd7,        3'd1, 32'd0,          1'b1};
    vecs[2] = '{32'd0,        32'd0,        3'd2, 32'hFFFF_FFFF,  1'b0};
    vecs[3] = '{32'h0000_00F0, 32'h0000_000F, 3'd3, 32'h0000_00FF, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 32'd0,         1'b1};
    vecs[5] = '{32'h0000_FF00, 32'h0000_0FF0, 3'd5, 32'h0000_0F00, 1'b0};
    vecs[6] = '{32'hAAAA_5555, 32'hAAAA_5555, 3'd6, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 32'd1,        3'd0, 32'd0,          1'b1};
    vecs[8] = '{32'd0,        32'd1,        3'd1, 32'hFFFF_FFFF,  1'b0};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    resetn        = 1'b0;

    // Reset state
    #3;
    chk_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_release", 64'(bus.in_ready), 64'(1));

    // Directed vectors with latency check: accept at E0, out_valid after E0+2.
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = vecs[i].a;
      bus.in_b     = vecs[i].b;
      bus.in_op    = vecs[i].op;
      chk("vec_in_ready", 64'(bus.in_ready), 64'(1));
      cycle();
      bus.in_valid = 1'b0;
      chk("vec_lat_e0", 64'(bus.out_valid), 64'(0));
      cycle();
      chk("vec_lat_e1", 64'(bus.out_valid), 64'(0));
      cycle();
      chk("vec_lat_e2", 64'(bus.out_valid), 64'(1));
      chk("vec_x", 64'(bus.out_x), 64'(vecs[i].x));
      chk("vec_z", 64'(bus.out_z), 64'(vecs[i].z));
      chk("vec_err", 64'(bus.out_err), 64'(0));
    end
    cycle();
    chk("vec_final_pop", 64'(bus.out_valid), 64'(0));

    // Backpressure: exactly 2*DEPTH accepts, then one result per cycle in order.
    sb_en         = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    accepts       = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_a  = 32'(i * 3 + 1);
      bus.in_b  = 32'(i);
      bus.in_op = 3'(i % 7);
      cycle();
    end
    chk("bp_accepts", 64'(accepts), 64'(2 * DEPTH));
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      chk("bp_stream_valid", 64'(bus.out_valid), 64'(1));
      cycle();
    end
    chk("bp_done_valid", 64'(bus.out_valid), 64'(0));
    chk("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // Random traffic against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_a      = $urandom;
      bus.in_b      = $urandom;
      bus.in_op     = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) begin
        bus.in_b  = bus.in_a;
        bus.in_op = 3'd1;
      end
      cycle();
    end
    drain(100);

    // Reset in mid-operation, then a single push yields only its own result.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_a  = 32'(100 + i);
      bus.in_b  = 32'd1;
      bus.in_op = 3'd0;
      cycle();
    end
    bus.in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'd9;
    bus.in_b      = 32'd1;
    bus.in_op     = 3'd0;
    outs = 0;
    cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("midrst_single_result", 64'(outs), 64'(1));
    chk("midrst_queue_empty", 64'(exp_q.size()), 64'(0));

`ifdef ALU_SEQ_OP_CHECK_EN
    // Illegal opcode between two adds.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a = 32'd1; bus.in_b = 32'd2; bus.in_op = 3'd0;
    cycle();
    bus.in_a = 32'd5; bus.in_b = 32'd6; bus.in_op = 3'd7;
    cycle();
    bus.in_a = 32'd3; bus.in_b = 32'd4; bus.in_op = 3'd0;
    cycle();
    bus.in_valid = 1'b0;
    chk("opchk_first_x", 64'(bus.out_x), 64'(3));
    cycle();
    chk("opchk_mid_err", 64'(bus.out_err), 64'(1));
    chk("opchk_mid_x", 64'(bus.out_x), 64'(0));
    cycle();
    chk("opchk_last_x", 64'(bus.out_x), 64'(7));
    chk("opchk_last_err", 64'(bus.out_err), 64'(0));
    drain(20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
